// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared IR frame constants and width-window helper
package ir_pkg;

  // Receiver FSM encoding, also visible on the debug state output
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GAP  = 2'd1;
  localparam logic [1:0] ST_MARK = 2'd2;

  // Abort causes reported on err_code
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_WIDTH = 2'b01;
  localparam logic [1:0] ERR_GAP   = 2'b10;

  // True when cnt lies in [w - tol, w + tol]; written without subtraction so
  // a window near zero never underflows.
  function automatic logic in_window(input int cnt, input int w, input int tol);
    return ((cnt + tol) >= w) && (cnt <= (w + tol));
  endfunction

endpackage

// File: rtl/ir_sample_tick.sv
// rtl/ir_sample_tick.sv - one-cycle sample tick every TICK_DIV clocks
module ir_sample_tick #(
  parameter int TICK_DIV = 2025
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div_cnt;

  // Free-running divider; tick is registered so the first one lands TICK_DIV
  // cycles after reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/ir_frame_receiver.sv
// rtl/ir_frame_receiver.sv - pulse-width IR frame decoder with error reporting
module ir_frame_receiver
  import ir_pkg::*;
#(
  parameter int DATA_BITS     = 12,
  parameter int TICK_DIV      = 2025,
  parameter int START_TICKS   = 32,
  parameter int ONE_TICKS     = 16,
  parameter int ZERO_TICKS    = 8,
  parameter int TOL           = 2,
  parameter int GAP_MAX_TICKS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] move_data,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [1:0]           state
);

  localparam int CNT_W = $clog2(START_TICKS + TOL + 2);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  logic                 tick;
  logic [1:0]           sync;
  logic                 s;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] bit_mask;
  logic [DATA_BITS-1:0] merged;
  logic                 start_ok;
  logic                 one_ok;
  logic                 zero_ok;
  logic                 gap_hit;
  logic                 last_bit;

  ir_sample_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchroniser for the asynchronous demodulator output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], data_in};
    end
  end

  assign s = sync[1];

  // Saturating increment: a long carrier parks cnt at all-ones instead of
  // wrapping back into a valid window.
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
  assign start_ok = in_window(int'(cnt), START_TICKS, TOL);
  assign one_ok   = in_window(int'(cnt), ONE_TICKS, TOL);
  assign zero_ok  = in_window(int'(cnt), ZERO_TICKS, TOL);
  assign gap_hit  = (int'(cnt_inc) >= GAP_MAX_TICKS);
  assign last_bit = (int'(idx) == DATA_BITS - 1);

  // Shift register with the bit currently being closed merged in at idx;
  // ONE is tested first so it wins if the windows ever overlap.
  assign bit_mask = DATA_BITS'(1) << idx;
  assign merged   = (shreg & ~bit_mask) | (one_ok ? bit_mask : '0);

  // Frame FSM: advances only on sample ticks, pulses are cleared every cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      move_data <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (s) begin
              cnt <= cnt_inc;
            end else begin
              // Lows that do not close a valid start mark are treated as noise
              cnt <= '0;
              if (start_ok) begin
                state <= ST_GAP;
                idx   <= '0;
              end
            end
          end
          ST_GAP: begin
            if (s) begin
              state <= ST_MARK;
              cnt   <= CNT_W'(1);
            end else if (gap_hit) begin
              error    <= 1'b1;
              err_code <= ERR_GAP;
              state    <= ST_IDLE;
              cnt      <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_MARK: begin
            if (s) begin
              cnt <= cnt_inc;
            end else begin
              cnt <= '0;
              if (one_ok || zero_ok) begin
                shreg <= merged;
                if (last_bit) begin
                  move_data <= merged;
                  done      <= 1'b1;
                  state     <= ST_IDLE;
                end else begin
                  idx   <= idx + 1'b1;
                  state <= ST_GAP;
                end
              end else begin
                error    <= 1'b1;
                err_code <= ERR_WIDTH;
                state    <= ST_IDLE;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_frame_receiver.sv
// tb/tb_ir_frame_receiver.sv - self-checking bench for ir_frame_receiver
module tb_ir_frame_receiver;

  localparam int START   = 32;
  localparam int ONE     = 16;
  localparam int ZERO    = 8;
  localparam int TOL     = 2;
  localparam int GAP_MAX = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        din1  = 1'b0;
  logic        din2  = 1'b0;
  logic [11:0] md1;
  logic        done1, error1;
  logic [1:0]  ec1, st1;
  logic [31:0] md2;
  logic        done2, error2;
  logic [1:0]  ec2, st2;

  ir_frame_receiver #(.DATA_BITS(12), .TICK_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .data_in(din1), .move_data(md1),
    .done(done1), .error(error1), .err_code(ec1), .state(st1)
  );

  ir_frame_receiver #(.DATA_BITS(32), .TICK_DIV(1)) dut2 (
    .clock(clock), .reset(reset), .data_in(din2), .move_data(md2),
    .done(done2), .error(error2), .err_code(ec2), .state(st2)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Pulse monitor: counts every cycle a pulse is high, so a stretched pulse
  // shows up as an extra count.
  int          done_n[2] = '{0, 0};
  int          err_n[2]  = '{0, 0};
  int          both_n[2] = '{0, 0};
  int          done_cyc[2];
  int          err_cyc[2];
  logic [31:0] last_w[2];
  logic [31:0] prev_w[2];
  logic [1:0]  err_st[2];

  always @(negedge clock) begin
    if (!reset) begin
      if (done1) begin
        done_n[0] <= done_n[0] + 1; done_cyc[0] <= cyc;
        prev_w[0] <= last_w[0]; last_w[0] <= {20'b0, md1};
      end
      if (error1) begin err_n[0] <= err_n[0] + 1; err_cyc[0] <= cyc; err_st[0] <= st1; end
      if (done1 && error1) both_n[0] <= both_n[0] + 1;
      if (done2) begin
        done_n[1] <= done_n[1] + 1; done_cyc[1] <= cyc;
        prev_w[1] <= last_w[1]; last_w[1] <= md2;
      end
      if (error2) begin err_n[1] <= err_n[1] + 1; err_cyc[1] <= cyc; err_st[1] <= st2; end
      if (done2 && error2) both_n[1] <= both_n[1] + 1;
    end
  end

  // Frame description: start width, then per bit a low gap and a high mark.
  // fr_gap[i] counts every low tick between the previous mark and mark i.
  int          fr_dut, fr_bits, fr_start;
  int          fr_mark[32];
  int          fr_gap[32];
  int          mark_end[32];
  logic [31:0] model_word[2];
  logic [1:0]  model_code[2];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] dut_word(input int d);
    return (d == 0) ? {20'b0, md1} : md2;
  endfunction

  function automatic logic [1:0] dut_code(input int d);
    return (d == 0) ? ec1 : ec2;
  endfunction

  function automatic bit near(input int v, input int w);
    return (v >= w - TOL) && (v <= w + TOL);
  endfunction

  // Frame-level reference: a bad start is ignored, otherwise the first bad
  // gap or mark aborts; the first low after a mark closes it, the remaining
  // lows of a gap count against GAP_MAX.
  function automatic void model_frame(output int e_done, output int e_err,
                                      output logic [1:0] e_code, output logic [31:0] e_word);
    logic [31:0] w;
    w = '0;
    e_done = 0; e_err = 0; e_code = 2'b00; e_word = '0;
    if (!near(fr_start, START)) return;
    for (int i = 0; i < fr_bits; i++) begin
      if (fr_gap[i] - 1 >= GAP_MAX) begin e_err = 1; e_code = 2'b10; return; end
      if (near(fr_mark[i], ONE)) w[i] = 1'b1;
      else if (near(fr_mark[i], ZERO)) w[i] = 1'b0;
      else begin e_err = 1; e_code = 2'b01; return; end
    end
    e_done = 1;
    e_word = w;
  endfunction

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      if (fr_dut == 0) din1 = v; else din2 = v;
      @(negedge clock);
    end
  endtask

  task automatic set_frame(input int d, input logic [31:0] word);
    fr_dut   = d;
    fr_bits  = (d == 0) ? 12 : 32;
    fr_start = START;
    for (int i = 0; i < 32; i++) begin
      fr_mark[i] = word[i] ? ONE : ZERO;
      fr_gap[i]  = 4;
    end
  endtask

  task automatic send_body();
    hold(1'b1, fr_start);
    for (int i = 0; i < fr_bits; i++) begin
      hold(1'b0, fr_gap[i]);
      hold(1'b1, fr_mark[i]);
      mark_end[i] = cyc;
    end
  endtask

  task automatic play(output int e_done, output int e_err,
                      output int o_done, output int o_err, output int o_both);
    int b_done, b_err, b_both;
    logic [1:0]  e_code;
    logic [31:0] e_word;
    model_frame(e_done, e_err, e_code, e_word);
    b_done = done_n[fr_dut]; b_err = err_n[fr_dut]; b_both = both_n[fr_dut];
    send_body();
    hold(1'b0, 8);
    o_done = done_n[fr_dut] - b_done;
    o_err  = err_n[fr_dut] - b_err;
    o_both = both_n[fr_dut] - b_both;
    if (e_done != 0) model_word[fr_dut] = e_word;
    if (e_err != 0) model_code[fr_dut] = e_code;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({st1, done1, error1, ec1, md1} !== '0) begin
      errors++;
      $display("FAIL reset_dut1: state=%0d done=%b error=%b err_code=%b move_data=%h, expected all zero", st1, done1, error1, ec1, md1);
    end
    checks++;
    if ({st2, done2, error2, ec2, md2} !== '0) begin
      errors++;
      $display("FAIL reset_dut2: state=%0d done=%b error=%b err_code=%b move_data=%h, expected all zero", st2, done2, error2, ec2, md2);
    end
    reset = 1'b0;
    model_word = '{32'h0, 32'h0};
    model_code = '{2'b00, 2'b00};
    repeat (4) @(negedge clock);
  endtask

  task automatic test_basic_frame();
    int ed, ee, od, oe, ob;
    set_frame(0, 32'hA5C);
    play(ed, ee, od, oe, ob);
    checks++;
    if (od !== 1 || oe !== 0 || ob !== 0 || ed !== 1) begin
      errors++;
      $display("FAIL basic_pulses: done=%0d error=%0d both=%0d, expected done=1 error=0 both=0", od, oe, ob);
    end
    checks++;
    if (md1 !== 12'hA5C) begin
      errors++; $display("FAIL basic_word: move_data=%h, expected a5c", md1);
    end
    checks++;
    if (done_cyc[0] - mark_end[11] !== 3) begin
      errors++; $display("FAIL basic_latency: %0d cycles, expected 3", done_cyc[0] - mark_end[11]);
    end
  endtask

  task automatic test_tolerance_edges();
    int ed, ee, od, oe, ob, b;
    logic [31:0] w;
    set_frame(0, 32'hA5C);
    for (int i = 0; i < 12; i++)
      fr_mark[i] = (fr_mark[i] == ONE) ? ($urandom_range(0, 1) ? ONE + TOL : ONE - TOL)
                                       : ($urandom_range(0, 1) ? ZERO + TOL : ZERO - TOL);
    play(ed, ee, od, oe, ob);
    checks++;
    if (od !== ed || oe !== ee || ob !== 0 || dut_word(0) !== model_word[0]) begin
      errors++;
      $display("FAIL edge_widths: done=%0d error=%0d word=%h, expected done=%0d error=%0d word=%h", od, oe, dut_word(0), ed, ee, model_word[0]);
    end
    set_frame(0, 32'hA5C);
    fr_mark[5] = 13;
    play(ed, ee, od, oe, ob);
    checks++;
    if (od !== ed || oe !== ee || ob !== 0 || ee !== 1) begin
      errors++; $display("FAIL mark13_pulses: done=%0d error=%0d, expected done=0 error=1", od, oe);
    end
    checks++;
    if (ec1 !== 2'b01 || md1 !== 12'hA5C) begin
      errors++; $display("FAIL mark13_state: err_code=%b move_data=%h, expected 01 and a5c", ec1, md1);
    end
    checks++;
    if (err_cyc[0] - mark_end[5] !== 3) begin
      errors++; $display("FAIL mark13_latency: %0d cycles, expected 3", err_cyc[0] - mark_end[5]);
    end
    w = $urandom;
    set_frame(0, w);
    b = $urandom_range(0, 11);
    fr_mark[b] = 12;
    play(ed, ee, od, oe, ob);
    checks++;
    if (od !== 0 || oe !== 1 || ec1 !== 2'b01 || dut_word(0) !== model_word[0]) begin
      errors++;
      $display("FAIL mark12_bit%0d: done=%0d error=%0d err_code=%b word=%h, expected 0 1 01 %h", b, od, oe, ec1, dut_word(0), model_word[0]);
    end
  endtask

  task automatic test_gap_timeout();
    int ed, ee, od, oe, ob;
    set_frame(0, $urandom);
    fr_gap[4] = 20;
    play(ed, ee, od, oe, ob);
    checks++;
    if (od !== 0 || oe !== 1 || ob !== 0) begin
      errors++; $display("FAIL gap_pulses: done=%0d error=%0d, expected done=0 error=1", od, oe);
    end
    checks++;
    if (ec1 !== 2'b10 || err_st[0] !== 2'd0 || dut_word(0) !== model_word[0]) begin
      errors++;
      $display("FAIL gap_state: err_code=%b state_at_error=%0d word=%h, expected 10 0 %h", ec1, err_st[0], dut_word(0), model_word[0]);
    end
  endtask

  task automatic test_bad_start();
    int ed, ee, od, oe, ob;
    int widths[2] = '{29, 96};
    for (int k = 0; k < 2; k++) begin
      set_frame(0, $urandom);
      fr_start = widths[k];
      play(ed, ee, od, oe, ob);
      checks++;
      if (od !== 0 || oe !== 0 || ec1 !== model_code[0] || md1 !== model_word[0][11:0]) begin
        errors++;
        $display("FAIL bad_start_%0d: done=%0d error=%0d err_code=%b word=%h, expected 0 0 %b %h", widths[k], od, oe, ec1, md1, model_code[0], model_word[0]);
      end
    end
    set_frame(0, 32'h001);
    play(ed, ee, od, oe, ob);
    checks++;
    if (od !== 1 || oe !== 0 || md1 !== 12'h001) begin
      errors++; $display("FAIL good_start: done=%0d error=%0d word=%h, expected 1 0 001", od, oe, md1);
    end
  endtask

  task automatic test_reset_mid_frame();
    int ed, ee, od, oe, ob, b_done, b_err;
    set_frame(0, 32'hFFF);
    hold(1'b1, fr_start);
    for (int i = 0; i < 7; i++) begin
      hold(1'b0, fr_gap[i]);
      hold(1'b1, fr_mark[i]);
    end
    hold(1'b0, 4);
    hold(1'b1, 5);
    reset = 1'b1;
    #1;
    checks++;
    if ({st1, done1, error1, ec1, md1} !== '0 || md2 !== '0) begin
      errors++;
      $display("FAIL midframe_reset: state=%0d done=%b error=%b err_code=%b word=%h word32=%h, expected all zero", st1, done1, error1, ec1, md1, md2);
    end
    @(negedge clock);
    b_done = done_n[0]; b_err = err_n[0];
    reset = 1'b0;
    model_word = '{32'h0, 32'h0};
    model_code = '{2'b00, 2'b00};
    hold(1'b0, 10);
    checks++;
    if (done_n[0] - b_done !== 0 || err_n[0] - b_err !== 0 || st1 !== 2'd0) begin
      errors++;
      $display("FAIL midframe_quiet: done=%0d error=%0d state=%0d, expected 0 0 0", done_n[0] - b_done, err_n[0] - b_err, st1);
    end
    set_frame(0, 32'hFFF);
    play(ed, ee, od, oe, ob);
    checks++;
    if (od !== 1 || oe !== 0 || md1 !== 12'hFFF) begin
      errors++; $display("FAIL after_reset_frame: done=%0d error=%0d word=%h, expected 1 0 fff", od, oe, md1);
    end
  endtask

  task automatic test_random_frames();
    int ed, ee, od, oe, ob;
    logic [31:0] w;
    for (int n = 0; n < 24; n++) begin
      set_frame(n % 2, 32'h0);
      w = $urandom;
      fr_start = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 40) : $urandom_range(START - TOL, START + TOL);
      for (int i = 0; i < fr_bits; i++) begin
        if ($urandom_range(0, 59) == 0) fr_mark[i] = $urandom_range(1, 20);
        else fr_mark[i] = w[i] ? $urandom_range(ONE - TOL, ONE + TOL) : $urandom_range(ZERO - TOL, ZERO + TOL);
        fr_gap[i] = ($urandom_range(0, 99) == 0) ? $urandom_range(17, 24) : $urandom_range(1, 15);
      end
      play(ed, ee, od, oe, ob);
      checks++;
      if (od !== ed || oe !== ee || ob !== 0 || dut_word(fr_dut) !== model_word[fr_dut] || dut_code(fr_dut) !== model_code[fr_dut]) begin
        errors++;
        $display("FAIL random_%0d dut%0d: done=%0d error=%0d word=%h code=%b, expected %0d %0d %h %b", n, fr_dut, od, oe, dut_word(fr_dut), dut_code(fr_dut), ed, ee, model_word[fr_dut], model_code[fr_dut]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int b_done, b_err;
    logic [31:0] wa, wb;
    set_frame(1, 32'hDEADBEEF);
    b_done = done_n[1]; b_err = err_n[1];
    send_body(); hold(1'b0, 1);
    send_body(); hold(1'b0, 8);
    checks++;
    if (done_n[1] - b_done !== 2 || err_n[1] - b_err !== 0 || prev_w[1] !== 32'hDEADBEEF || last_w[1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL b2b_32: done=%0d error=%0d words=%h,%h, expected 2 0 deadbeef,deadbeef", done_n[1] - b_done, err_n[1] - b_err, prev_w[1], last_w[1]);
    end
    wa = {20'b0, 12'($urandom)};
    wb = {20'b0, 12'($urandom)};
    b_done = done_n[0];
    set_frame(0, wa); send_body(); hold(1'b0, 1);
    set_frame(0, wb); send_body(); hold(1'b0, 8);
    checks++;
    if (done_n[0] - b_done !== 2 || prev_w[0] !== wa || last_w[0] !== wb) begin
      errors++;
      $display("FAIL b2b_12: done=%0d words=%h,%h, expected 2 %h,%h", done_n[0] - b_done, prev_w[0], last_w[0], wa, wb);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_tolerance_edges();
    test_gap_timeout();
    test_bad_start();
    test_reset_mid_frame();
    test_random_frames();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded 90000 cycles, expected completion");
    $fatal(1);
  end

endmodule
